// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: sequences a settle-timed external divider; define ALU_DIV_SIGNED_EN for signed operands
module alu_div_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quo,
    output logic [15:0] rem,
    output logic        div_err,
    output logic [15:0] dv_dividend,
    output logic [14:0] dv_divisor,
    input  logic [15:0] dv_quo,
    input  logic [15:0] dv_rem
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q, done_q, err_q, neg_q_q, neg_r_q;
    logic [15:0] quo_q, rem_q, dd_q, dvd_q;
    logic [14:0] dvs_q;
    logic        sa, sb, op_err;
    logic [15:0] a_mag, quo_d, rem_d;
    logic [14:0] b_mag;
`ifdef ALU_DIV_SIGNED_EN
    assign sa     = dividend[15];
    assign sb     = divisor[15];
    assign op_err = divisor == 16'h0000 || divisor == 16'h8000;
`else
    assign sa     = 1'b0;
    assign sb     = 1'b0;
    assign op_err = divisor == 16'h0000 || divisor[15];
`endif
    // the divider sees magnitudes; signs are reapplied when the result is captured
    assign a_mag = sa ? 16'(-dividend) : dividend;
    assign b_mag = sb ? 15'(-divisor[14:0]) : divisor[14:0];
    assign quo_d = neg_q_q ? 16'(-dv_quo) : dv_quo;
    assign rem_d = neg_r_q ? 16'(-dv_rem) : dv_rem;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dd_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    dvd_q   <= a_mag;
                    dvs_q   <= b_mag;
                    dd_q    <= dividend;
                    neg_q_q <= sa ^ sb;
                    neg_r_q <= sa;
                    busy_q  <= 1'b1;
                    cnt_q   <= op_err ? 4'd0 : 4'(SETTLE_CYCLES - 1);
                    state_q <= op_err ? ERR : WAIT;
                end
                WAIT: if (cnt_q == 4'd0) begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                ERR: begin
                    quo_q   <= 16'hFFFF;
                    rem_q   <= dd_q;
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign quo         = quo_q;
    assign rem         = rem_q;
    assign div_err     = err_q;
    assign dv_dividend = dvd_q;
    assign dv_divisor  = dvs_q;
endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb_alu_div_sequencer: directed and random checks of the divider sequencer against an arithmetic model
module tb_alu_div_sequencer;
    localparam int SETTLE = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0, divisor = '0;
    logic        busy, done, div_err;
    logic [15:0] quo, rem, dv_dividend, dv_quo, dv_rem;
    logic [14:0] dv_divisor;
    int nvec = 0, nerr = 0;
    alu_div_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quo(quo), .rem(rem), .div_err(div_err),
        .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_quo(dv_quo), .dv_rem(dv_rem)
    );
    // external divider behaviour: unsigned magnitude division
    assign dv_quo = dv_divisor == '0 ? 16'hFFFF : dv_dividend / {1'b0, dv_divisor};
    assign dv_rem = dv_divisor == '0 ? dv_dividend : dv_dividend % {1'b0, dv_divisor};
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nvec++;
        assert (obs === want) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic [15:0] dva, output logic [14:0] dvb, output logic e);
`ifdef ALU_DIV_SIGNED_EN
        int sa, sb;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        e   = (sb == 0) || (sb == -32768);
        dva = 16'(sa < 0 ? -sa : sa);
        dvb = 15'(sb < 0 ? -sb : sb);
        if (e) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end
`else
        e   = (b == 0) || (b >= 16'h8000);
        dva = a;
        dvb = b[14:0];
        if (e) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // called just after the accepting edge; returns edges until done is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            chk("busy_wait", busy, 1);
            tick();
            lat++;
        end
    endtask
    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done === 1'b1) c++;
        end
    endtask
    task automatic do_op(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er, ea;
        logic [14:0] eb;
        logic ee;
        int lat;
        model(a, b, eq, er, ea, eb, ee);
        start = 1'b1;
        dividend = a;
        divisor = b;
        tick();
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            chk("busy_wait", busy, 1);
            if (!ee) begin
                chk("dv_dividend", dv_dividend, ea);
                chk("dv_divisor", dv_divisor, eb);
            end
            tick();
            lat++;
        end
        chk("latency", lat, ee ? 1 : SETTLE);
        chk("busy_done", busy, 0);
        chk("quo", quo, eq);
        chk("rem", rem, er);
        chk("div_err", div_err, ee);
        tick();
        chk("done_pulse", done, 0);
        chk("quo_hold", quo, eq);
        chk("rem_hold", rem, er);
    endtask
    initial begin
        int lat, c, sel;
        logic [15:0] ra, rb;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", div_err, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dvd", dv_dividend, 0);
        chk("rst_dvs", dv_divisor, 0);
`ifndef ALU_DIV_SIGNED_EN
        do_op(16'd100, 16'd7);
        chk("u_100_7_quo", quo, 14);
        chk("u_100_7_rem", rem, 2);
        do_op(16'h1234, 16'h0000);
        chk("dz_quo", quo, 16'hFFFF);
        chk("dz_rem", rem, 16'h1234);
        chk("dz_err", div_err, 1);
        do_op(16'd9, 16'h8000);
        chk("range_err", div_err, 1);
        do_op(16'd65535, 16'd255);
        chk("u_max_quo", quo, 257);
        chk("u_max_rem", rem, 0);
        chk("u_max_err", div_err, 0);
`else
        do_op(16'hFFF9, 16'd2);
        chk("s_m7_2_quo", quo, 16'hFFFD);
        chk("s_m7_2_rem", rem, 16'hFFFF);
        do_op(16'd7, 16'hFFFE);
        chk("s_7_m2_quo", quo, 16'hFFFD);
        chk("s_7_m2_rem", rem, 16'h0001);
        do_op(16'd5, 16'h8000);
        chk("s_min_err", div_err, 1);
`endif
        // start while busy is ignored
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dividend = 16'd20; divisor = 16'd3;
        tick();
        start = 1'b0;
        lat = 2;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("ign_latency", lat, SETTLE);
        chk("ign_quo", quo, 10);
        chk("ign_rem", rem, 0);
        count_done(10, c);
        chk("ign_no_extra_done", c, 0);
        // start in the done cycle is accepted
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("b2b_first_quo", quo, 10);
        start = 1'b1; dividend = 16'd20; divisor = 16'd3;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done(lat);
        chk("b2b_latency", lat, SETTLE);
        chk("b2b_quo", quo, 6);
        chk("b2b_rem", rem, 2);
        // reset aborts an operation in flight
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quo", quo, 0);
        chk("abort_rem", rem, 0);
        chk("abort_err", div_err, 0);
        chk("abort_dvd", dv_dividend, 0);
        chk("abort_dvs", dv_divisor, 0);
        count_done(10, c);
        chk("abort_no_done", c, 0);
        do_op(16'd100, 16'd7);
        // reset wins over start
        rst = 1'b1; start = 1'b1; dividend = 16'd77; divisor = 16'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_dvd", dv_dividend, 0);
        count_done(8, c);
        chk("rst_prio_no_done", c, 0);
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (sel == 0) rb = 16'h0000;
            else if (sel == 1) rb = 16'h8000 | rb;
            else if (sel == 2) rb = 16'($urandom_range(1, 15));
            else if (sel == 3) ra = 16'($urandom_range(0, 20));
            do_op(ra, rb);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
